mealy_bit_feeder: RTL

Upstream serializer for the lab's Mealy sequence FSM. It accepts a parallel test word through a valid/ready handshake and emits it one bit per clock on a registered serial output, which drives the FSM's `in` input. Back-to-back words stream with no gap cycles. A flush aborts a word in progress. A wrap-around counter records how many words were completed.

---
 rtl/lab_fsm_pkg.sv | 20 ++
 rtl/mealy_bit_feeder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lab_fsm_pkg.sv
// rtl/lab_fsm_pkg.sv - shared constants for the Mealy sequence lab: feeder states, defaults, FSM state codes
package lab_fsm_pkg;

    // Feeder state encoding (two-state control FSM)
    localparam logic FEED_IDLE  = 1'b0;
    localparam logic FEED_SHIFT = 1'b1;

    // Default feeder geometry
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Mealy sequence FSM state codes, so benches can decode its state next to the feeder
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;

endpackage

// File: rtl/mealy_bit_feeder.sv
// rtl/mealy_bit_feeder.sv - parallel-to-serial word feeder for the Mealy sequence FSM
module mealy_bit_feeder
    import lab_fsm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_word,
    output logic             load_ready,
    input  logic             flush,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic             state_q,     state_d;
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             bit_out_q,   bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             last_bit_q,  last_bit_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic at_last;
    logic accept;

    // Handshake: a new word may enter when idle or while the final bit of the current word is on the line
    always_comb begin
        at_last    = (state_q == FEED_SHIFT) && (idx_q == IDX_LAST);
        load_ready = !rst && !flush && ((state_q == FEED_IDLE) || at_last);
        accept     = load_valid && load_ready;
    end

    // Next-state logic: flush beats accept beats normal shifting; reset is applied in the register block
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = bit_valid_q;
        last_bit_d  = last_bit_q;
        cnt_d       = cnt_q;

        if (flush) begin
            // Abandon the word; the counter only counts words that were fully shifted
            state_d     = FEED_IDLE;
            idx_d       = '0;
            bit_out_d   = 1'b0;
            bit_valid_d = 1'b0;
            last_bit_d  = 1'b0;
        end else if (accept) begin
            // First bit goes straight to the output register; the rest waits in shreg
            if (at_last) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d     = FEED_SHIFT;
            idx_d       = '0;
            bit_valid_d = 1'b1;
            last_bit_d  = 1'b0;
            if (MSB_FIRST != 0) begin
                bit_out_d = load_word[WIDTH-1];
                shreg_d   = load_word << 1;
            end else begin
                bit_out_d = load_word[0];
                shreg_d   = load_word >> 1;
            end
        end else if (state_q == FEED_SHIFT) begin
            if (at_last) begin
                // Word complete with nothing queued behind it
                cnt_d       = cnt_q + CNT_W'(1);
                state_d     = FEED_IDLE;
                idx_d       = '0;
                bit_out_d   = 1'b0;
                bit_valid_d = 1'b0;
                last_bit_d  = 1'b0;
            end else begin
                idx_d       = idx_q + IDX_W'(1);
                bit_valid_d = 1'b1;
                last_bit_d  = ((idx_q + IDX_W'(1)) == IDX_LAST);
                if (MSB_FIRST != 0) begin
                    bit_out_d = shreg_q[WIDTH-1];
                    shreg_d   = shreg_q << 1;
                end else begin
                    bit_out_d = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                end
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FEED_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            last_bit_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            last_bit_q  <= last_bit_d;
            cnt_q       <= cnt_d;
        end
    end

    // Registered outputs; busy is the control state itself
    always_comb begin
        bit_out    = bit_out_q;
        bit_valid  = bit_valid_q;
        last_bit   = last_bit_q;
        busy       = (state_q == FEED_SHIFT);
        words_sent = cnt_q;
    end

endmodule
